multicycle_controller: RTL and testbench

Control FSM that sequences the RV32I datapath (program counter, instruction/data memory, register file, sign extender, ALU, result mux) over multiple cycles per instruction. All datapath resources, including a single shared memory port, are time-multiplexed under its control. It replaces the combinational select/enable wiring with Moore-style state outputs plus a memory request/ready handshake. It also detects unsupported instructions and traps on them.

---
 rtl/multicycle_controller.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore-style datapath selects plus a shared memory req/ready handshake.
// Defining MCC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [2:0]  alu_ctrl,
`ifdef MCC_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic        illegal_instr
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_alu_f3_legal;
    logic [2:0] w_alu_op;
    logic [2:0] w_imm_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    assign w_alu_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                            (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_R:    w_next_state = w_alu_f3_legal ? S_EXECR : S_TRAP;
                    OP_I:    w_next_state = w_alu_f3_legal ? S_EXECI : S_TRAP;
                    OP_BR:   w_next_state = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:  w_next_state = S_JAL;
                    default: w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // funct7b5 selects sub only for register-register ops; addi ignores it.
    always_comb begin
        case (funct3)
            3'b000:  w_alu_op = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_op = ALU_SLT;
            3'b110:  w_alu_op = ALU_OR;
            3'b111:  w_alu_op = ALU_AND;
            default: w_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE: w_imm_dec = 3'b001;
            OP_BR:    w_imm_dec = 3'b010;
            OP_JAL:   w_imm_dec = 3'b011;
            default:  w_imm_dec = 3'b000;
        endcase
    end

    // Every output is forced low during reset so an in-flight memory request is dropped at once.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        imm_src       = 3'b000;
        alu_ctrl      = ALU_ADD;
        illegal_instr = 1'b0;
        if (!rst) begin
            if (r_state != S_TRAP) imm_src = w_imm_dec;
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = w_alu_op;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_ctrl  = w_alu_op;
                end
                S_ALUWB:  reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = ALU_SUB;
                    pc_write  = alu_zero;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_TRAP:   illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MCC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;
    logic        w_retire;

    assign w_retire = (w_next_state == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire)          r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules from a reference model feed a
// stimulus queue; a negedge monitor pops expected control vectors (and counters if enabled).
module tb_multicycle_controller;
    localparam int W = 19;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_ctrl;
`ifdef MCC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .alu_ctrl(alu_ctrl),
`ifdef MCC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         mr;
        logic         az;
        logic [6:0]   op;
        logic [2:0]   f3;
        logic         f7;
        logic         trap;
        logic         last;
        logic [W-1:0] exp;
    } step_t;

    step_t        stim_q[$];
    logic [W-1:0] exp_q[$];
    logic [63:0]  cnt_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           n_step = 0;
    logic [6:0]   m_op;
    logic [2:0]   m_f3;
    logic         m_f7;
    logic [31:0]  m_cyc;
    logic [31:0]  m_ins;

    wire logic [W-1:0] w_got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                                alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl,
                                illegal_instr};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_STORE) return 3'b001;
        if (op == OP_BR)    return 3'b010;
        if (op == OP_JAL)   return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [W-1:0] ctl(input logic mreq, input logic mw, input logic adr,
                                         input logic irw, input logic pcw, input logic rw,
                                         input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] rs, input logic [2:0] alu);
        return {mreq, mw, adr, irw, pcw, rw, a, b, rs, imm_of(m_op), alu, 1'b0};
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    task automatic push(input logic r, input logic mr, input logic az, input logic [W-1:0] e,
                        input logic tr, input logic ls);
        step_t s;
        s.rst = r; s.mr = mr; s.az = az; s.op = m_op; s.f3 = m_f3; s.f7 = m_f7;
        s.trap = tr; s.last = ls; s.exp = e;
        stim_q.push_back(s);
    endtask

    task automatic push_reset();
        push(1'b1, rb(), rb(), '0, 1'b0, 1'b0);
    endtask

    // One instruction: fetch waits, decode, then the class-specific cycle schedule.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input int wf, input int wm, input logic az);
        logic legal_f3;
        logic trap;
        m_op = op; m_f3 = f3; m_f7 = f7;
        legal_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        trap = 1'b0;
        for (int i = 0; i < wf; i++)
            push(1'b0, 1'b0, rb(), ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000), 1'b0, 1'b0);
        push(1'b0, 1'b1, rb(), ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000), 1'b0, 1'b0);
        push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b000), 1'b0, 1'b0);
        if (op == OP_LOAD || op == OP_STORE) begin
            push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000), 1'b0, 1'b0);
            for (int i = 0; i <= wm; i++)
                push(1'b0, (i == wm), rb(),
                     ctl(1'b1, (op == OP_STORE), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000),
                     1'b0, (op == OP_STORE) && (i == wm));
            if (op == OP_LOAD)
                push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000), 1'b0, 1'b1);
        end else if ((op == OP_R || op == OP_I) && legal_f3) begin
            push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                 (op == OP_R) ? 2'b00 : 2'b01, 2'b00, ref_alu(f3, (op == OP_R) && f7)), 1'b0, 1'b0);
            push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000), 1'b0, 1'b1);
        end else if (op == OP_BR && f3 == 3'b000) begin
            push(1'b0, rb(), az, ctl(1'b0, 1'b0, 1'b0, 1'b0, az, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001), 1'b0, 1'b1);
        end else if (op == OP_JAL) begin
            push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000), 1'b0, 1'b0);
            push(1'b0, rb(), rb(), ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000), 1'b0, 1'b1);
        end else begin
            trap = 1'b1;
        end
        if (trap) begin
            for (int i = 0; i < 12; i++)
                push(1'b0, rb(), rb(), {{(W-1){1'b0}}, 1'b1}, 1'b1, 1'b0);
            push_reset();
        end
    endtask

    function automatic logic [2:0] legal_f3_pick();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL ctl step %0d: got %b expected %b", n_step, w_got, e);
            end
`ifdef MCC_PERF_CNT_EN
            if (cnt_q.size() > 0) begin
                logic [63:0] c;
                c = cnt_q.pop_front();
                n_tests++;
                if ({cycle_cnt, instret_cnt} !== c) begin
                    n_fail++;
                    $display("FAIL cnt step %0d: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                             n_step, cycle_cnt, instret_cnt, c[63:32], c[31:0]);
                end
            end
`endif
            n_step++;
        end
    end

    initial begin
        m_op = 7'd0; m_f3 = 3'd0; m_f7 = 1'b0;
        m_cyc = 32'd0; m_ins = 32'd0;

        push_reset();
        issue(OP_R, 3'b000, 1'b1, 0, 0, 1'b0);
        issue(OP_LOAD, 3'b010, 1'b0, 0, 2, 1'b0);
        issue(OP_BR, 3'b000, 1'b0, 0, 0, 1'b1);
        issue(OP_BR, 3'b000, 1'b0, 0, 0, 1'b0);
        issue(7'b1110011, 3'b000, 1'b0, 0, 0, 1'b0);
        issue(OP_STORE, 3'b010, 1'b0, 1, 3, 1'b0);
        void'(stim_q.pop_back());
        push_reset();
        issue(OP_I, 3'b000, 1'b0, 0, 0, 1'b0);
        issue(OP_I, 3'b000, 1'b1, 0, 0, 1'b0);
        issue(OP_I, 3'b000, 1'b0, 0, 0, 1'b0);
        issue(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        issue(OP_R, 3'b001, 1'b0, 0, 0, 1'b0);
        issue(OP_BR, 3'b001, 1'b0, 0, 0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            int k;
            int wf;
            int wm;
            k  = int'($urandom_range(0, 9));
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            wm = int'($urandom_range(0, 3));
            case (k)
                0: issue(OP_LOAD, 3'($urandom), rb(), wf, wm, rb());
                1: issue(OP_STORE, 3'($urandom), rb(), wf, wm, rb());
                2: issue(OP_R, legal_f3_pick(), rb(), wf, wm, rb());
                3: issue(OP_I, legal_f3_pick(), rb(), wf, wm, rb());
                4: issue(OP_BR, 3'b000, rb(), wf, wm, rb());
                5: issue(OP_JAL, 3'($urandom), rb(), wf, wm, rb());
                6: issue(OP_R, 3'($urandom), rb(), wf, wm, rb());
                7: issue(OP_BR, 3'($urandom), rb(), wf, wm, rb());
                8: issue(7'($urandom), 3'($urandom), rb(), wf, wm, rb());
                default: issue(OP_I, 3'($urandom), rb(), wf, wm, rb());
            endcase
        end

        // Driver: inputs change 1 time unit after the rising edge.
        foreach (stim_q[i]) begin
            step_t s;
            s = stim_q[i];
            @(posedge clk);
            #1;
            rst = s.rst; mem_ready = s.mr; alu_zero = s.az;
            opcode = s.op; funct3 = s.f3; funct7b5 = s.f7;
            exp_q.push_back(s.exp);
`ifdef MCC_PERF_CNT_EN
            if (s.rst) begin
                cnt_q.push_back(64'd0);
                m_cyc = 32'd0;
                m_ins = 32'd0;
            end else begin
                cnt_q.push_back({m_cyc, m_ins});
                if (!s.trap) m_cyc = m_cyc + 32'd1;
                if (s.last)  m_ins = m_ins + 32'd1;
            end
`endif
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
